axi4_mem_arbiter: RTL and testbench
===================================

Name: axi4_mem_arbiter

Overview:
- Shares one single-port synchronous word memory (the `axi4_memory` instance type) between a write-burst engine and a read-burst engine.
- Round-robin ownership, burst-locked grants, and a hold limit for fairness.
- Registered memory command issue, a fixed-latency read-return pipeline, and out-of-range error signalling.
- Sits between the AXI4 slave channel FSMs and the memory.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 16, byte address width from requesters
MEMORY_DEPTH, 1024, memory words; MEM_AW = $clog2(MEMORY_DEPTH)
MAX_HOLD, 16, max beats an owner keeps the memory while the other side waits (>=1)

Ports:
ACLK  in  1  clock
ARESETn  in  1  synchronous active-low reset
wr_req  in  1  write beat request
wr_addr  in  ADDR_WIDTH  write byte address
wr_data  in  DATA_WIDTH  write data
wr_last  in  1  final beat of write burst
wr_gnt  out  1  write beat accepted this cycle
wr_err  out  1  pulse: accepted write beat out of range
rd_req  in  1  read beat request
rd_addr  in  ADDR_WIDTH  read byte address
rd_last  in  1  final beat of read burst
rd_gnt  out  1  read beat accepted this cycle
rd_valid  out  1  read data return strobe
rd_data  out  DATA_WIDTH  read data
rd_err  out  1  read beat out of range, qualified by rd_valid
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  MEM_AW  word address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a mem_en read cycle

Behaviour:
Clock and reset:
- One clock, ACLK.
- Reset is synchronous, active-low, on ARESETn, sampled at the ACLK rising edge.
- Reset values: all outputs 0, owner state S_IDLE, rr_ptr = WR, hold_cnt = 0, read pipeline cleared.
- Reset mid-burst drops in-flight read returns; no rd_valid is produced for them.

State machine (owner):
- States: S_IDLE, S_WR, S_RD.
- S_IDLE: no grants.
  - Next state S_WR if only wr_req; S_RD if only rd_req.
  - If both, the side given by rr_ptr. Arbitration costs 1 cycle.
- S_WR: wr_gnt = wr_req (combinational); rd_gnt = 0. S_RD mirrors this.
- Beat: a cycle with req && gnt. Each beat increments hold_cnt, saturating at MAX_HOLD.
- Release after a beat when wr_last/rd_last is 1, OR when hold_cnt reaches MAX_HOLD and the other side's req is 1.
  - On release: rr_ptr = other side; hold_cnt = 0.
  - Next state is the other owner if its req is 1 in that cycle, else S_IDLE.
  - Direct handoff has no idle bubble.
- Owner with req low and no release: stays owner and grants nothing.
- Hold-limit release mid-burst is legal. The preempted engine re-requests and resumes after regaining ownership.

Memory command (1-cycle registered):
- A beat in cycle N drives mem_en/mem_we/mem_addr/mem_wdata in cycle N+1.
- mem_en = 0 and mem_we = 0 in every cycle without a beat.
- Word address = addr >> 2, truncated to MEM_AW.
- Out of range: (addr >> 2) >= MEMORY_DEPTH.
  - The beat is still granted, but no memory access is issued (mem_en = 0).
  - Write: wr_err pulses in cycle N+1.

Read return:
- Read beat in cycle N: mem_en in N+1; rd_valid = 1 in N+2 with rd_data = mem_rdata.
- Out-of-range read beat: rd_valid = 1 in N+2 with rd_err = 1 and rd_data = 0.
- rd_err = 0 whenever rd_valid = 0.
- Back-to-back read beats give back-to-back rd_valid. Returns stay in order, 2-deep pipeline, no backpressure.

Simultaneous events:
- wr_req and rd_req both high in S_IDLE: rr_ptr decides (WR after reset).
- Release and new requests in the same cycle: evaluated in the same edge.

Test Plan:
- Reset, then wr_req with wr_addr=0x0010, wr_data=0xDEADBEEF, wr_last=1 -> S_IDLE 1 cycle; wr_gnt next cycle; following cycle mem_en=1, mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF; then S_IDLE.
- Read 1 beat rd_addr=0x0010 after that write -> rd_gnt in cycle N; mem_en=1, mem_we=0, mem_addr=4 in N+1; rd_valid=1, rd_data=0xDEADBEEF, rd_err=0 in N+2.
- wr_req and rd_req both high from S_IDLE after reset, 2-beat bursts each -> write beats granted first, then read granted on the cycle after wr_last with no idle cycle; rr_ptr = WR again afterward.
- MAX_HOLD=4, 8-beat write burst with rd_req held high -> 4 wr_gnt, then 1-beat read granted, then write regains ownership and completes its remaining 4 beats.
- wr_addr=0x1000 (word 1024, out of range) -> wr_gnt=1, mem_en=0, wr_err pulse. rd_addr=0x1004 -> rd_valid=1 with rd_err=1, rd_data=0.
- ARESETn=0 for 1 cycle, one cycle after a read grant -> no rd_valid for that beat; all outputs 0; state S_IDLE.

Source files
------------

// File: rtl/axi4_mem_arbiter.sv
// Round-robin, burst-locked arbiter that shares one single-port word memory
// between the write-burst and read-burst engines of an AXI4 slave.
module axi4_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024,
    parameter int MAX_HOLD     = 16,
    localparam int MEM_AW      = $clog2(MEMORY_DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  wr_gnt,
    output logic                  wr_err,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_last,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [31:0] DEPTH_W = 32'(MEMORY_DEPTH);
    localparam logic RR_WR = 1'b0;
    localparam logic RR_RD = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    state_t          state, state_nxt;
    logic            rr_ptr, rr_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt, hold_inc;
    logic            hold_hit, wr_rel, rd_rel;
    logic            beat, beat_oor;
    logic [ADDR_WIDTH-1:0] beat_addr, beat_word;
    logic            rd_p1, rd_p1_err;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state    <= S_IDLE;
            rr_ptr   <= RR_WR;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    assign hold_hit = (hold_inc == HOLD_MAX);
    assign wr_rel   = wr_gnt && (wr_last || (hold_hit && rd_req));
    assign rd_rel   = rd_gnt && (rd_last || (hold_hit && wr_req));

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        hold_nxt  = hold_cnt;
        unique case (state)
            S_IDLE: begin
                if (wr_req && (!rd_req || rr_ptr == RR_WR))
                    state_nxt = S_WR;
                else if (rd_req)
                    state_nxt = S_RD;
            end
            S_WR: begin
                if (wr_rel) begin
                    state_nxt = rd_req ? S_RD : S_IDLE;
                    rr_nxt    = RR_RD;
                    hold_nxt  = '0;
                end else if (wr_gnt) begin
                    hold_nxt = hold_inc;
                end
            end
            S_RD: begin
                if (rd_rel) begin
                    state_nxt = wr_req ? S_WR : S_IDLE;
                    rr_nxt    = RR_WR;
                    hold_nxt  = '0;
                end else if (rd_gnt) begin
                    hold_nxt = hold_inc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grants are masked while reset is held so every output reads 0.
    always_comb begin
        wr_gnt = ARESETn && (state == S_WR) && wr_req;
        rd_gnt = ARESETn && (state == S_RD) && rd_req;
    end

    assign beat      = wr_gnt || rd_gnt;
    assign beat_addr = wr_gnt ? wr_addr : rd_addr;
    assign beat_word = beat_addr >> 2;
    assign beat_oor  = 32'(beat_word) >= DEPTH_W;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_err    <= 1'b0;
            rd_p1     <= 1'b0;
            rd_p1_err <= 1'b0;
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            mem_en    <= beat && !beat_oor;
            mem_we    <= wr_gnt && !beat_oor;
            wr_err    <= wr_gnt && beat_oor;
            if (beat)
                mem_addr <= beat_word[MEM_AW-1:0];
            if (wr_gnt)
                mem_wdata <= wr_data;
            rd_p1     <= rd_gnt;
            rd_p1_err <= rd_gnt && beat_oor;
            rd_valid  <= rd_p1;
            rd_err    <= rd_p1 && rd_p1_err;
        end
    end

    // Memory data lands in the rd_valid cycle; error returns carry zero.
    assign rd_data = (rd_valid && !rd_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed bench for axi4_mem_arbiter with a behavioural single-port memory.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_axi4_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int DEPTH = 1024;
    localparam int HOLD = 4;
    localparam int MAW = 10;

    logic           ACLK = 1'b0;
    logic           ARESETn;
    logic           wr_req, wr_last, wr_gnt, wr_err;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [DW-1:0]  wr_data, rd_data, mem_wdata, mem_rdata;
    logic           rd_req, rd_last, rd_gnt, rd_valid, rd_err;
    logic           mem_en, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi4_mem_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MEMORY_DEPTH(DEPTH), .MAX_HOLD(HOLD)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_last(wr_last), .wr_gnt(wr_gnt), .wr_err(wr_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_err(rd_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic mid();
        @(negedge ACLK);
    endtask

    // {wr_gnt, rd_gnt, mem_en, mem_we, wr_err, rd_valid, rd_err}
    function automatic logic [6:0] flags();
        return {wr_gnt, rd_gnt, mem_en, mem_we, wr_err, rd_valid, rd_err};
    endfunction

    task automatic test_reset();
        ARESETn = 1'b0;
        wr_req = 0; wr_last = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_last = 0; rd_addr = '0;
        tick(); tick(); mid();
        checks++;
        if (flags() !== 7'b0 || mem_addr !== '0 || mem_wdata !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset: flags=%b addr=%h wdata=%h rdata=%h want all 0",
                     flags(), mem_addr, mem_wdata, rd_data);
        end
        tick(); ARESETn = 1'b1;
    endtask

    task automatic test_single_write();
        tick(); wr_req = 1; wr_addr = 16'h0010; wr_data = 32'hDEADBEEF; wr_last = 1;
        mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL wr_arb: got %b want %b", flags(), 7'b0000000);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b1000000) begin
            errors++; $display("FAIL wr_gnt: got %b want %b", flags(), 7'b1000000);
        end
        tick(); wr_req = 0; mid(); checks++;
        if (flags() !== 7'b0011000 || mem_addr !== 10'd4 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_cmd: flags=%b addr=%h wdata=%h want 0011000 004 deadbeef",
                     flags(), mem_addr, mem_wdata);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL wr_done: got %b want %b", flags(), 7'b0000000);
        end
    endtask

    task automatic test_single_read();
        tick(); rd_req = 1; rd_addr = 16'h0010; rd_last = 1;
        mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL rd_arb: got %b want %b", flags(), 7'b0000000);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0100000) begin
            errors++; $display("FAIL rd_gnt: got %b want %b", flags(), 7'b0100000);
        end
        tick(); rd_req = 0; mid(); checks++;
        if (flags() !== 7'b0010000 || mem_addr !== 10'd4) begin
            errors++;
            $display("FAIL rd_cmd: flags=%b addr=%h want 0010000 004", flags(), mem_addr);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0000010 || rd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_ret: flags=%b data=%h want 0000010 deadbeef", flags(), rd_data);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL rd_done: got %b want %b", flags(), 7'b0000000);
        end
    endtask

    task automatic test_both_requests();
        tick(); ARESETn = 0;
        tick(); ARESETn = 1;
        wr_req = 1; wr_addr = 16'h0020; wr_data = 32'h11111111; wr_last = 0;
        rd_req = 1; rd_addr = 16'h0010; rd_last = 0;
        mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL both_arb: got %b want %b", flags(), 7'b0000000);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b1000000) begin
            errors++; $display("FAIL both_w1: got %b want %b", flags(), 7'b1000000);
        end
        tick(); wr_addr = 16'h0024; wr_data = 32'h22222222; wr_last = 1;
        mid(); checks++;
        if (flags() !== 7'b1011000) begin
            errors++; $display("FAIL both_w2: got %b want %b", flags(), 7'b1011000);
        end
        tick(); wr_req = 0; mid(); checks++;
        if (flags() !== 7'b0111000) begin
            errors++; $display("FAIL both_r1: got %b want %b", flags(), 7'b0111000);
        end
        tick(); rd_addr = 16'h0020; rd_last = 1; mid(); checks++;
        if (flags() !== 7'b0110000 || mem_addr !== 10'd4) begin
            errors++;
            $display("FAIL both_r2: flags=%b addr=%h want 0110000 004", flags(), mem_addr);
        end
        tick(); rd_req = 0; mid(); checks++;
        if (flags() !== 7'b0010010 || mem_addr !== 10'd8 || rd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL both_ret1: flags=%b addr=%h data=%h want 0010010 008 deadbeef",
                     flags(), mem_addr, rd_data);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0000010 || rd_data !== 32'h11111111) begin
            errors++;
            $display("FAIL both_ret2: flags=%b data=%h want 0000010 11111111", flags(), rd_data);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL both_idle: got %b want %b", flags(), 7'b0000000);
        end
        // Pointer must be back on the write side after the read release.
        tick();
        wr_req = 1; wr_addr = 16'h0028; wr_data = 32'h33333333; wr_last = 1;
        rd_req = 1; rd_addr = 16'h0024; rd_last = 1;
        mid(); tick(); mid(); checks++;
        if (flags() !== 7'b1000000) begin
            errors++; $display("FAIL rr_back_wr: got %b want %b", flags(), 7'b1000000);
        end
        tick(); wr_req = 0; mid(); checks++;
        if (flags() !== 7'b0111000) begin
            errors++; $display("FAIL rr_rd: got %b want %b", flags(), 7'b0111000);
        end
        tick(); rd_req = 0; mid(); tick(); mid(); checks++;
        if (flags() !== 7'b0000010 || rd_data !== 32'h22222222) begin
            errors++;
            $display("FAIL rr_ret: flags=%b data=%h want 0000010 22222222", flags(), rd_data);
        end
    endtask

    task automatic test_hold_limit();
        logic [1:0] exp_g [11] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        int   beat = 0;
        logic rd_done = 1'b0;
        for (int c = 0; c < 11; c++) begin
            tick();
            wr_req  = (beat < 8);
            wr_addr = AW'(16'h0100 + 4 * beat);
            wr_data = DW'(beat + 1);
            wr_last = (beat == 7);
            rd_req  = !rd_done;
            rd_addr = 16'h0010;
            rd_last = 1;
            mid(); checks++;
            if ({wr_gnt, rd_gnt} !== exp_g[c]) begin
                errors++;
                $display("FAIL hold_c%0d: gnt got %b want %b", c, {wr_gnt, rd_gnt}, exp_g[c]);
            end
            if (wr_gnt) beat++;
            if (rd_gnt) rd_done = 1'b1;
        end
        checks++;
        if (beat != 8 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== 10'h047 || mem_wdata !== 32'd8) begin
            errors++;
            $display("FAIL hold_tail: beats=%0d en=%b we=%b addr=%h wdata=%h want 8 1 1 047 8",
                     beat, mem_en, mem_we, mem_addr, mem_wdata);
        end
        wr_req = 0; rd_req = 0;
    endtask

    task automatic test_out_of_range();
        tick(); wr_req = 1; wr_addr = 16'h0FFC; wr_data = 32'hCAFEF00D; wr_last = 1;
        mid(); tick(); tick(); wr_req = 0; mid(); checks++;
        if (flags() !== 7'b0011000 || mem_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL top_word: flags=%b addr=%h want 0011000 3ff", flags(), mem_addr);
        end
        tick(); wr_req = 1; wr_addr = 16'h1000; wr_data = 32'hAAAA5555;
        mid(); tick(); mid(); checks++;
        if (flags() !== 7'b1000000) begin
            errors++; $display("FAIL oor_wgnt: got %b want %b", flags(), 7'b1000000);
        end
        tick(); wr_req = 0; mid(); checks++;
        if (flags() !== 7'b0000100) begin
            errors++; $display("FAIL oor_werr: got %b want %b", flags(), 7'b0000100);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL oor_wpulse: got %b want %b", flags(), 7'b0000000);
        end
        tick(); rd_req = 1; rd_addr = 16'h1004; rd_last = 1;
        mid(); tick(); mid(); checks++;
        if (flags() !== 7'b0100000) begin
            errors++; $display("FAIL oor_rgnt: got %b want %b", flags(), 7'b0100000);
        end
        tick(); rd_req = 0; mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL oor_rnomem: got %b want %b", flags(), 7'b0000000);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0000011 || rd_data !== '0) begin
            errors++;
            $display("FAIL oor_rerr: flags=%b data=%h want 0000011 0", flags(), rd_data);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL oor_rdone: got %b want %b", flags(), 7'b0000000);
        end
    endtask

    task automatic test_reset_mid_burst();
        tick(); rd_req = 1; rd_addr = 16'h0010; rd_last = 0;
        mid(); tick(); mid(); checks++;
        if (flags() !== 7'b0100000) begin
            errors++; $display("FAIL rst_gnt: got %b want %b", flags(), 7'b0100000);
        end
        tick(); rd_req = 0; ARESETn = 0; mid(); checks++;
        if (flags() !== 7'b0010000) begin
            errors++; $display("FAIL rst_cmd: got %b want %b", flags(), 7'b0010000);
        end
        tick(); ARESETn = 1; mid(); checks++;
        if (flags() !== 7'b0 || mem_addr !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL rst_clear: flags=%b addr=%h data=%h want all 0",
                     flags(), mem_addr, rd_data);
        end
        tick(); mid(); checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL rst_drop: rd_valid got %b want 0", rd_valid);
        end
        tick();
        wr_req = 1; wr_addr = 16'h0030; wr_data = 32'h44444444; wr_last = 1;
        rd_req = 1; rd_addr = 16'h0010; rd_last = 1;
        mid(); checks++;
        if (flags() !== 7'b0000000) begin
            errors++; $display("FAIL rst_idle: got %b want %b", flags(), 7'b0000000);
        end
        tick(); mid(); checks++;
        if (flags() !== 7'b1000000) begin
            errors++; $display("FAIL rst_wfirst: got %b want %b", flags(), 7'b1000000);
        end
        tick(); wr_req = 0; mid(); tick(); rd_req = 0; mid(); tick(); mid(); checks++;
        if (flags() !== 7'b0000010 || rd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rst_resume: flags=%b data=%h want 0000010 deadbeef", flags(), rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_both_requests();
        test_hold_limit();
        test_out_of_range();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
